// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter that runs one source->destination move on the shared register bus per grant.
// Latency: grant one cycle after req is sampled in IDLE, write strobe and done one cycle after that (3 cycles/transfer).
// Backpressure: requesters hold req (level) until granted; a granted transfer always completes unless reset.
module bus_transfer_arbiter #(
   parameter int WIDTH   = 8,
   parameter int N_PORTS = 2,
   parameter int N_REQ   = 4,
   localparam int PSEL_W = $clog2(N_PORTS),
   localparam int RSEL_W = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*PSEL_W-1:0]    req_from,
   input  logic [N_REQ*PSEL_W-1:0]    req_to,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           done,
   output logic                       busy,
   input  logic [N_PORTS*WIDTH-1:0]   bus_in,
   output logic [PSEL_W-1:0]          bus_from,
   output logic [PSEL_W-1:0]          bus_to,
   output logic [WIDTH-1:0]           bus_out,
   output logic [N_PORTS-1:0]         bus_we
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t              state;
   logic [RSEL_W-1:0]   ptr;       // highest-priority requester for the next arbitration
   logic [RSEL_W-1:0]   gidx;      // requester that owns the current transfer
   logic [WIDTH-1:0]    hold;      // value read from the source port; also drives bus_out

   logic                win_vld;
   logic [RSEL_W-1:0]   win_idx;
   logic [PSEL_W-1:0]   win_from;
   logic [PSEL_W-1:0]   win_to;
   logic [WIDTH-1:0]    rd_dat;
   logic [N_PORTS-1:0]  we_dec;

   // bus_out is the holding register itself, so it keeps its value between transfers
   assign bus_out = hold;

   // Round-robin pick: scan from ptr upward with wrap; descending loop lets the nearest win
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_from = '0;
      win_to   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N_REQ]) begin
            win_vld  = 1'b1;
            win_idx  = RSEL_W'((int'(ptr) + k) % N_REQ);
            win_from = req_from[((int'(ptr) + k) % N_REQ) * PSEL_W +: PSEL_W];
            win_to   = req_to[((int'(ptr) + k) % N_REQ) * PSEL_W +: PSEL_W];
         end
      end
   end

   // Source read mux and destination strobe decode; an index with no matching port reads 0 / writes nothing
   always_comb begin
      rd_dat = '0;
      we_dec = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (bus_from == PSEL_W'(p)) rd_dat = bus_in[p*WIDTH +: WIDTH];
         if (bus_to == PSEL_W'(p))   we_dec[p] = 1'b1;
      end
   end

   // Transfer FSM: IDLE arbitrates, READ latches source data, WRITE strobes the destination
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         gidx     <= '0;
         hold     <= '0;
         gnt      <= '0;
         done     <= '0;
         busy     <= 1'b0;
         bus_we   <= '0;
         bus_from <= '0;
         bus_to   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state    <= READ;
                  gidx     <= win_idx;
                  gnt      <= N_REQ'(1) << win_idx;
                  busy     <= 1'b1;
                  bus_from <= win_from;
                  bus_to   <= win_to;
               end
            end
            READ: begin
               state  <= WRITE;
               hold   <= rd_dat;
               bus_we <= we_dec;
               done   <= gnt;
            end
            WRITE: begin
               state    <= IDLE;
               gnt      <= '0;
               done     <= '0;
               bus_we   <= '0;
               busy     <= 1'b0;
               bus_from <= '0;
               bus_to   <= '0;
               ptr      <= (gidx == RSEL_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter: reset in each state, single move, round-robin order,
// fairness between two requesters, source data latched in READ, reset abort.
module tb_bus_transfer_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  req_from;
   logic [3:0]  req_to;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [15:0] bus_in;
   logic        bus_from;
   logic        bus_to;
   logic [7:0]  bus_out;
   logic [1:0]  bus_we;

   int          n_cmp;
   int          n_err;
   logic [3:0]  exp_g;

   bus_transfer_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_from (req_from),
      .req_to   (req_to),
      .gnt      (gnt),
      .done     (done),
      .busy     (busy),
      .bus_in   (bus_in),
      .bus_from (bus_from),
      .bus_to   (bus_to),
      .bus_out  (bus_out),
      .bus_we   (bus_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " gnt"},      32'(gnt),      32'h0);
      check({tag, " done"},     32'(done),     32'h0);
      check({tag, " busy"},     32'(busy),     32'h0);
      check({tag, " bus_we"},   32'(bus_we),   32'h0);
      check({tag, " bus_from"}, 32'(bus_from), 32'h0);
      check({tag, " bus_to"},   32'(bus_to),   32'h0);
      check({tag, " bus_out"},  32'(bus_out),  32'h0);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      req_from = 4'b0000;
      req_to   = 4'b0000;
      bus_in   = 16'h0000;

      // reset in IDLE
      tick(); tick();
      check_idle_zero("rst_idle");

      // single move: requester 0, port0 -> port1; req dropped after grant
      rst      = 1'b0;
      req      = 4'b0001;
      req_from = 4'b0000;
      req_to   = 4'b0001;
      bus_in   = 16'hAA05;
      tick();
      check("t2 gnt read",  32'(gnt),      32'h1);
      check("t2 busy read", 32'(busy),     32'h1);
      check("t2 from",      32'(bus_from), 32'h0);
      check("t2 to",        32'(bus_to),   32'h1);
      check("t2 we read",   32'(bus_we),   32'h0);
      check("t2 done read", 32'(done),     32'h0);
      req = 4'b0000;
      tick();
      check("t2 gnt write", 32'(gnt),     32'h1);
      check("t2 we write",  32'(bus_we),  32'h2);
      check("t2 out write", 32'(bus_out), 32'h05);
      check("t2 done",      32'(done),    32'h1);
      tick();
      check("t2 gnt idle",  32'(gnt),     32'h0);
      check("t2 done idle", 32'(done),    32'h0);
      check("t2 we idle",   32'(bus_we),  32'h0);
      check("t2 busy idle", 32'(busy),    32'h0);
      check("t2 out hold",  32'(bus_out), 32'h05);

      // ptr is now 1: requester 3 wins; reset in READ aborts it
      req      = 4'b1000;
      req_from = 4'b1000;
      req_to   = 4'b0001;
      tick();
      check("t6 gnt3", 32'(gnt), 32'h8);
      rst = 1'b1;
      req = 4'b1001;
      tick();
      check_idle_zero("rst_read1");
      tick();
      check_idle_zero("rst_read2");
      rst = 1'b0;
      tick();
      check("t6 ptr0 wins", 32'(gnt), 32'h1);
      tick();
      check("t6 we write", 32'(bus_we), 32'h2);
      check("t6 done",     32'(done),   32'h1);

      // reset in WRITE
      rst = 1'b1;
      tick();
      check_idle_zero("rst_write1");
      tick();
      check_idle_zero("rst_write2");

      // all four requesting from reset: 0,1,2,3,0 every 3 cycles
      req      = 4'b1111;
      req_from = 4'b1010;
      req_to   = 4'b0101;
      rst      = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         tick();
         exp_g = (c % 3 == 0) ? 4'b0000 : (4'b0001 << (((c - 1) / 3) % 4));
         check($sformatf("t3 gnt c%0d", c),  32'(gnt),  32'(exp_g));
         check($sformatf("t3 done c%0d", c), 32'(done), (c % 3 == 2) ? 32'(exp_g) : 32'h0);
      end

      // fairness: req1 held, req0 dropped at its done and re-asserted next cycle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      req = 4'b0011;
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp_g = (c % 3 == 0) ? 4'b0000 : (4'b0001 << (((c - 1) / 3) % 2));
         check($sformatf("t4 gnt c%0d", c), 32'(gnt), 32'(exp_g));
         req[0] = (done != 4'b0001);
      end

      // src == dst, bus_in changes during WRITE: the READ value is written
      rst = 1'b1;
      tick(); tick();
      rst      = 1'b0;
      req      = 4'b0100;
      req_from = 4'b0100;
      req_to   = 4'b0100;
      bus_in   = 16'h1000;
      tick();
      check("t5 gnt",  32'(gnt),      32'h4);
      check("t5 from", 32'(bus_from), 32'h1);
      check("t5 to",   32'(bus_to),   32'h1);
      req = 4'b0000;
      tick();
      bus_in = 16'hFF00;
      check("t5 out",  32'(bus_out), 32'h10);
      check("t5 we",   32'(bus_we),  32'h2);
      check("t5 done", 32'(done),    32'h4);
      tick();
      check("t5 out hold", 32'(bus_out), 32'h10);
      check("t5 we idle",  32'(bus_we),  32'h0);
      check("t5 busy",     32'(busy),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
